// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and the mul/div unit,
// with an MD result FIFO and pending scoreboard. Optional starvation guard: MDWB_STARVE_GUARD_EN.
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WB_VALID,
  input  logic [4:0]  WB_RD,
  input  logic [31:0] WB_DATA,
  output logic        WB_HOLD,
  input  logic        MD_VALID,
  input  logic [4:0]  MD_RD,
  input  logic [31:0] MD_DATA,
  output logic        MD_READY,
  input  logic        ISSUE_MD,
  input  logic [4:0]  ISSUE_RD,
  input  logic [4:0]  DEC_RS1,
  input  logic [4:0]  DEC_RS2,
  input  logic [4:0]  DEC_RD,
  output logic        STALL,
  output logic [31:0] PENDING,
  output logic        RF_WE,
  output logic [4:0]  RF_WADDR,
  output logic [31:0] RF_WDATA
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [36:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pending;
  logic          rf_we_q;
  logic [4:0]    rf_waddr_q;
  logic [31:0]   rf_wdata_q;
  logic          wb_hold;
  logic          full, empty, wb_accept, push, md_keep, drain, bypass, enq, sel_we;
  logic [4:0]    sel_addr, head_rd;
  logic [31:0]   sel_data, head_data, set_mask, clr_mask;

  // MD handshake: a result transfers on any cycle with MD_VALID && MD_READY.
  // MD_READY depends only on FIFO occupancy and RESET, never on MD_VALID.
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign MD_READY = !full && !RESET;
  assign {head_rd, head_data} = fifo_mem[rd_ptr];

  always_comb begin
    wb_accept = WB_VALID && (WB_RD != 5'd0) && !wb_hold;
    push      = MD_VALID && MD_READY;
    md_keep   = push && (MD_RD != 5'd0);
    drain     = !wb_accept && !empty;
    bypass    = !wb_accept && empty && md_keep;
    enq       = md_keep && !bypass;
    sel_we    = wb_accept || drain || bypass;
    sel_addr  = 5'd0;
    sel_data  = 32'd0;
    clr_mask  = 32'd0;
    set_mask  = 32'd0;
    if (wb_accept) begin
      sel_addr = WB_RD;
      sel_data = WB_DATA;
    end else if (drain) begin
      sel_addr = head_rd;
      sel_data = head_data;
      clr_mask = 32'd1 << head_rd;
    end else if (bypass) begin
      sel_addr = MD_RD;
      sel_data = MD_DATA;
      clr_mask = 32'd1 << MD_RD;
    end
    if (ISSUE_MD && (ISSUE_RD != 5'd0)) set_mask = 32'd1 << ISSUE_RD;
  end

  always_ff @(posedge CLK) begin
    if (enq) fifo_mem[wr_ptr] <= {MD_RD, MD_DATA};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (drain) rd_ptr <= rd_ptr + AW'(1);
      if (enq && !drain) count <= count + CW'(1);
      else if (!enq && drain) count <= count - CW'(1);
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_ff @(posedge CLK) begin
    if (RESET) pending <= 32'd0;
    else pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      rf_we_q <= sel_we;
      if (sel_we) begin
        rf_waddr_q <= sel_addr;
        rf_wdata_q <= sel_data;
      end
    end
  end

`ifdef MDWB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  // Counts cycles the FIFO head waits behind WB; one forced-drain cycle at the limit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      starve_cnt <= '0;
      wb_hold    <= 1'b0;
    end else begin
      wb_hold <= 1'b0;
      if (empty || drain) begin
        starve_cnt <= '0;
      end else if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
        starve_cnt <= '0;
        wb_hold    <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = |STARVE_LIMIT;
  assign wb_hold = 1'b0;
`endif

  assign WB_HOLD  = wb_hold;
  assign PENDING  = pending;
  assign RF_WE    = rf_we_q;
  assign RF_WADDR = rf_waddr_q;
  assign RF_WDATA = rf_wdata_q;
  assign STALL    = ((DEC_RS1 != 5'd0) && pending[DEC_RS1]) ||
                    ((DEC_RS2 != 5'd0) && pending[DEC_RS2]) ||
                    ((DEC_RD  != 5'd0) && pending[DEC_RD]);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected register writes are queued in
// hand-computed order and a monitor checks every RF write against the queue.
module tb_regfile_wb_arbiter;
  logic        CLK, RESET;
  logic        WB_VALID, WB_HOLD, MD_VALID, MD_READY, ISSUE_MD, STALL, RF_WE;
  logic [4:0]  WB_RD, MD_RD, ISSUE_RD, DEC_RS1, DEC_RS2, DEC_RD, RF_WADDR;
  logic [31:0] WB_DATA, MD_DATA, PENDING, RF_WDATA;

  logic [36:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_DATA(WB_DATA), .WB_HOLD(WB_HOLD),
    .MD_VALID(MD_VALID), .MD_RD(MD_RD), .MD_DATA(MD_DATA), .MD_READY(MD_READY),
    .ISSUE_MD(ISSUE_MD), .ISSUE_RD(ISSUE_RD),
    .DEC_RS1(DEC_RS1), .DEC_RS2(DEC_RS2), .DEC_RD(DEC_RD),
    .STALL(STALL), .PENDING(PENDING),
    .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    WB_VALID = 0; WB_RD = 0; WB_DATA = 0;
    MD_VALID = 0; MD_RD = 0; MD_DATA = 0;
    ISSUE_MD = 0; ISSUE_RD = 0;
    DEC_RS1 = 0; DEC_RS2 = 0; DEC_RD = 0;
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({rd, data});
  endtask

  // Scoreboard monitor: every RF write must match the queue head
  always @(posedge CLK) begin
    #1;
    if (RF_WE === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write", RF_WADDR, RF_WDATA);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({RF_WADDR, RF_WDATA} !== e) begin
          n_fail++;
          $display("FAIL rf_write: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
                   RF_WADDR, RF_WDATA, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    int idx, cyc, hold_cnt, hold_at;
    idle_inputs();
    // Reset with MD_VALID asserted
    RESET = 1; MD_VALID = 1; MD_RD = 5'd3; MD_DATA = 32'h3333;
    repeat (2) @(negedge CLK);
    check("reset_rf_we", RF_WE, 0);
    check("reset_md_ready", MD_READY, 0);
    check("reset_pending", PENDING, 0);
    check("reset_wb_hold", WB_HOLD, 0);
    RESET = 0; MD_VALID = 0;
    #1 check("md_ready_after_reset", MD_READY, 1);

    // Bypass and hazard
    @(negedge CLK);
    ISSUE_MD = 1; ISSUE_RD = 5'd5;
    @(negedge CLK);
    ISSUE_MD = 0;
    check("pending5_set", PENDING, 32'h20);
    DEC_RS2 = 5'd5;
    #1 check("stall_rs2", STALL, 1);
    DEC_RS2 = 5'd0;
    #1 check("stall_zero_regs", STALL, 0);
    DEC_RD = 5'd5;
    #1 check("stall_waw", STALL, 1);
    DEC_RD = 5'd0; DEC_RS2 = 5'd5;
    repeat (2) @(negedge CLK);
    MD_VALID = 1; MD_RD = 5'd5; MD_DATA = 32'h0000_0C35;
    expect_write(5'd5, 32'h0000_0C35);
    #1 check("stall_before_select", STALL, 1);
    @(negedge CLK);
    MD_VALID = 0;
    check("bypass_rf_we", RF_WE, 1);
    check("bypass_waddr", RF_WADDR, 5);
    check("bypass_wdata", RF_WDATA, 32'h0000_0C35);
    check("bypass_pending_clear", PENDING, 0);
    check("stall_dropped", STALL, 0);
    DEC_RS2 = 5'd0;

    // Priority and full FIFO
    ISSUE_MD = 1; ISSUE_RD = 5'd7;
    @(negedge CLK);
    ISSUE_RD = 5'd8;
    @(negedge CLK);
    ISSUE_MD = 0;
    expect_write(5'd1, 32'h1001); expect_write(5'd2, 32'h2002);
    expect_write(5'd3, 32'h3003); expect_write(5'd4, 32'h4004);
    expect_write(5'd7, 32'h7007); expect_write(5'd8, 32'h8008);
    WB_VALID = 1; WB_RD = 5'd1; WB_DATA = 32'h1001;
    MD_VALID = 1; MD_RD = 5'd7; MD_DATA = 32'h7007;
    @(negedge CLK);
    WB_RD = 5'd2; WB_DATA = 32'h2002;
    MD_RD = 5'd8; MD_DATA = 32'h8008;
    @(negedge CLK);
    MD_VALID = 0;
    check("full_md_ready", MD_READY, 0);
    check("pending_7_8", PENDING, 32'h180);
    WB_RD = 5'd3; WB_DATA = 32'h3003;
    @(negedge CLK);
    WB_RD = 5'd4; WB_DATA = 32'h4004;
    check("no_hold_short_block", WB_HOLD, 0);
    @(negedge CLK);
    WB_VALID = 0;
    @(negedge CLK);
    check("drain1_waddr", {RF_WE, RF_WADDR}, {1'b1, 5'd7});
    @(negedge CLK);
    check("drain2_waddr", {RF_WE, RF_WADDR}, {1'b1, 5'd8});
    @(negedge CLK);
    check("idle_rf_we", RF_WE, 0);
    check("drained_md_ready", MD_READY, 1);
    check("drained_pending", PENDING, 0);

    // Zero-register handling
    ISSUE_MD = 1; ISSUE_RD = 5'd9;
    @(negedge CLK);
    ISSUE_MD = 0;
    expect_write(5'd10, 32'h0A0A); expect_write(5'd9, 32'h9999);
    WB_VALID = 1; WB_RD = 5'd10; WB_DATA = 32'h0A0A;
    MD_VALID = 1; MD_RD = 5'd9; MD_DATA = 32'h9999;
    @(negedge CLK);
    MD_VALID = 0;
    WB_RD = 5'd0; WB_DATA = 32'h0BAD;
    @(negedge CLK);
    check("wb_rd0_drain", {RF_WE, RF_WADDR, RF_WDATA}, {1'b1, 5'd9, 32'h9999});
    WB_VALID = 0;
    MD_VALID = 1; MD_RD = 5'd0; MD_DATA = 32'hDEAD;
    #1 check("md_rd0_ready", MD_READY, 1);
    @(negedge CLK);
    MD_VALID = 0;
    check("md_rd0_no_write", RF_WE, 0);
    check("md_rd0_pending", PENDING, 0);

    // Continuous WB with one buffered MD entry
    ISSUE_MD = 1; ISSUE_RD = 5'd12;
    @(negedge CLK);
    ISSUE_MD = 0;
`ifdef MDWB_STARVE_GUARD_EN
    for (int i = 0; i < 5; i++) expect_write(5'(13 + i), 32'h5000 + i);
    expect_write(5'd12, 32'hC0C0);
    expect_write(5'd18, 32'h5005);
`else
    for (int i = 0; i < 6; i++) expect_write(5'(13 + i), 32'h5000 + i);
    expect_write(5'd12, 32'hC0C0);
`endif
    idx = 0; cyc = 0; hold_cnt = 0; hold_at = 0;
    while (idx < 6 && cyc < 20) begin
      cyc++;
      WB_VALID = 1; WB_RD = 5'(13 + idx); WB_DATA = 32'h5000 + idx;
      MD_VALID = (cyc == 1); MD_RD = 5'd12; MD_DATA = 32'hC0C0;
      #1;
`ifdef MDWB_STARVE_GUARD_EN
      if (cyc == 7) check("starve_drain_waddr", {RF_WE, RF_WADDR}, {1'b1, 5'd12});
`endif
      if (WB_HOLD === 1'b1) begin
        hold_cnt++;
        hold_at = cyc;
      end else begin
        idx++;
      end
      @(negedge CLK);
    end
    idle_inputs();
`ifdef MDWB_STARVE_GUARD_EN
    check("starve_hold_count", hold_cnt, 1);
    check("starve_hold_cycle", hold_at, 6);
`else
    check("no_guard_hold_count", hold_cnt, 0);
`endif
    repeat (3) @(negedge CLK);
    check("starve_pending_clear", PENDING, 0);
    check("queue_empty", exp_q.size(), 0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
